// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Turns a taken jump/branch report from the execute stage into a redirect
// request to fetch. The request is held with a handshake, then IF/ID is
// flushed for FLUSH_CYCLES more cycles while execute issue is stalled.
// Misaligned targets are not redirected and raise a one-cycle error pulse.
//
// Parameters
//   FLUSH_CYCLES  flush cycles after the redirect is accepted (0..15)
//   PC_W          program-counter width
//
// Ports
//   clk             sole clock, rising edge
//   reset_n         synchronous active-low reset
//   jb_enable       taken redirect reported this cycle
//   jb_target_pc    redirect target, qualified by jb_enable
//   redirect_ready  fetch accepts the redirect this cycle
//   redirect_valid  redirect request to fetch (registered)
//   redirect_pc     latched target, stable while redirect_valid=1
//   flush           kill IF/ID contents (registered)
//   stall_ex        hold execute issue (registered)
//   misalign_err    one-cycle pulse for a non 4-byte-aligned target
//   redirect_count  accepted-redirect counter, saturating
//                   (present only when BRANCH_REDIRECT_STATS_EN is defined)
//
// Build option
//   BRANCH_REDIRECT_STATS_EN  adds the redirect_count port and its counter.
// -----------------------------------------------------------------------------
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PC_W         = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            jb_enable,
  input  logic [PC_W-1:0] jb_target_pc,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            stall_ex,
  output logic            misalign_err
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  output logic [31:0]     redirect_count
`endif
);

  localparam int unsigned CNT_W = 4;
  // The drain counter counts down to zero, so it is loaded with one less than
  // the number of drain cycles. FLUSH_CYCLES=0 skips DRAIN entirely.
  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    (FLUSH_CYCLES == 0) ? '0 : CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;
  logic              stall_q, stall_d;
  logic              misalign_q, misalign_d;
  logic              handshake;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0]       count_q, count_d;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    handshake  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (jb_enable) begin
          if (jb_target_pc[1:0] == 2'b00) begin
            pc_d    = jb_target_pc;
            state_d = ST_REQ;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // jb_enable here comes from younger, flushed instructions: ignored.
        if (redirect_ready) begin
          handshake = 1'b1;
          if (FLUSH_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered copies decoded from the next state, so they
    // appear in the first cycle after the sampling edge.
    valid_d = (state_d == ST_REQ);
    flush_d = (state_d != ST_IDLE);
    stall_d = (state_d != ST_IDLE);
  end

`ifdef BRANCH_REDIRECT_STATS_EN
  always_comb begin
    count_d = count_q;
    if (handshake && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      stall_q    <= 1'b0;
      misalign_q <= 1'b0;
`ifdef BRANCH_REDIRECT_STATS_EN
      count_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      stall_q    <= stall_d;
      misalign_q <= misalign_d;
`ifdef BRANCH_REDIRECT_STATS_EN
      count_q    <= count_d;
`endif
    end
  end

  assign redirect_valid = valid_q;
  assign redirect_pc    = pc_q;
  assign flush          = flush_q;
  assign stall_ex       = stall_q;
  assign misalign_err   = misalign_q;
`ifdef BRANCH_REDIRECT_STATS_EN
  assign redirect_count = count_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//
// Drives two instances of branch_redirect_ctrl from the same inputs, one with
// FLUSH_CYCLES=2 and one with FLUSH_CYCLES=0, and compares both against a
// behavioural model: a pending-redirect flag plus a count of flush cycles
// still owed after the handshake. Directed steps first, then random traffic.
// -----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        jb_enable;
  logic [31:0] jb_target_pc;
  logic        redirect_ready;

  logic [1:0]        o_valid;
  logic [1:0][31:0]  o_pc;
  logic [1:0]        o_flush;
  logic [1:0]        o_stall;
  logic [1:0]        o_mis;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [1:0][31:0]  o_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .PC_W(32)) dut_fc2 (
    .clk            (clk),
    .reset_n        (reset_n),
    .jb_enable      (jb_enable),
    .jb_target_pc   (jb_target_pc),
    .redirect_ready (redirect_ready),
    .redirect_valid (o_valid[0]),
    .redirect_pc    (o_pc[0]),
    .flush          (o_flush[0]),
    .stall_ex       (o_stall[0]),
    .misalign_err   (o_mis[0])
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    .redirect_count (o_cnt[0])
`endif
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(0), .PC_W(32)) dut_fc0 (
    .clk            (clk),
    .reset_n        (reset_n),
    .jb_enable      (jb_enable),
    .jb_target_pc   (jb_target_pc),
    .redirect_ready (redirect_ready),
    .redirect_valid (o_valid[1]),
    .redirect_pc    (o_pc[1]),
    .flush          (o_flush[1]),
    .stall_ex       (o_stall[1]),
    .misalign_err   (o_mis[1])
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    .redirect_count (o_cnt[1])
`endif
  );

  // Reference model, one entry per instance.
  int          m_fc    [2] = '{2, 0};
  bit          m_pend  [2];
  int          m_owed  [2];
  logic [31:0] m_pc    [2];
  bit          m_mis   [2];
  logic [31:0] m_cnt   [2];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_pend[i] = 1'b0;
        m_owed[i] = 0;
        m_pc[i]   = '0;
        m_mis[i]  = 1'b0;
        m_cnt[i]  = '0;
      end else begin
        m_mis[i] = 1'b0;
        if (m_pend[i]) begin
          if (redirect_ready) begin
            m_pend[i] = 1'b0;
            m_owed[i] = m_fc[i];
            if (m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
          end
        end else if (m_owed[i] > 0) begin
          m_owed[i] = m_owed[i] - 1;
        end else if (jb_enable) begin
          if (jb_target_pc % 4 == 0) begin
            m_pend[i] = 1'b1;
            m_pc[i]   = jb_target_pc;
          end else begin
            m_mis[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      string sfx;
      bit    busy;
      sfx  = (i == 0) ? "/fc2" : "/fc0";
      busy = m_pend[i] || (m_owed[i] > 0);
      check({tag, sfx, " valid"}, 32'(o_valid[i]), 32'(m_pend[i]));
      check({tag, sfx, " pc"},    o_pc[i],         m_pc[i]);
      check({tag, sfx, " flush"}, 32'(o_flush[i]), 32'(busy));
      check({tag, sfx, " stall"}, 32'(o_stall[i]), 32'(busy));
      check({tag, sfx, " mis"},   32'(o_mis[i]),   32'(m_mis[i]));
`ifdef BRANCH_REDIRECT_STATS_EN
      check({tag, sfx, " count"}, o_cnt[i],        m_cnt[i]);
`endif
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check
  // 1 ns after the edge.
  task automatic step(input string tag, input bit en, input logic [31:0] pc,
                      input bit rdy, input bit rst_n);
    reset_n        = rst_n;
    jb_enable      = en;
    jb_target_pc   = pc;
    redirect_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 1'b0; m_owed[i] = 0; m_pc[i] = '0;
      m_mis[i]  = 1'b0; m_cnt[i]  = '0;
    end

    // Reset, with a jb_enable on the reset edge that must be discarded.
    step("rst0", 1'b0, 32'h0, 1'b0, 1'b0);
    step("rst1", 1'b1, 32'h0000_0080, 1'b1, 1'b0);

    // Basic redirect, ready immediately: 1 REQ + 2 DRAIN cycles.
    step("b_acc",  1'b1, 32'h0000_0100, 1'b1, 1'b1);
    step("b_hs",   1'b0, 32'h0, 1'b1, 1'b1);
    step("b_dr1",  1'b0, 32'h0, 1'b1, 1'b1);
    step("b_dr2",  1'b0, 32'h0, 1'b0, 1'b1);
    step("b_idle", 1'b0, 32'h0, 1'b1, 1'b1);

    // Misaligned target in IDLE.
    step("mis",    1'b1, 32'h0000_0102, 1'b1, 1'b1);
    step("mis_1",  1'b0, 32'h0, 1'b0, 1'b1);

    // Held request with younger jb_enable pulses in REQ and DRAIN.
    step("h_acc",  1'b1, 32'h0000_0200, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step("h_wait", 1'b1, 32'h0000_0300, 1'b0, 1'b1);
    step("h_wmis", 1'b1, 32'h0000_0303, 1'b0, 1'b1);
    step("h_hs",   1'b1, 32'h0000_0300, 1'b1, 1'b1);
    step("h_dr1",  1'b1, 32'h0000_0300, 1'b0, 1'b1);
    step("h_dr2",  1'b1, 32'h0000_0300, 1'b1, 1'b1);
    // Back-to-back: first IDLE cycle after DRAIN accepts a new redirect.
    step("bb_acc", 1'b1, 32'h0000_0340, 1'b1, 1'b1);
    step("bb_hs",  1'b0, 32'h0, 1'b1, 1'b1);
    step("bb_dr1", 1'b0, 32'h0, 1'b0, 1'b1);
    step("bb_dr2", 1'b0, 32'h0, 1'b0, 1'b1);

    // Reset during DRAIN, then a normal redirect.
    step("r_acc",  1'b1, 32'h0000_0500, 1'b1, 1'b1);
    step("r_hs",   1'b0, 32'h0, 1'b1, 1'b1);
    step("r_rst",  1'b0, 32'h0, 1'b1, 1'b0);
    step("r_new",  1'b1, 32'h0000_0400, 1'b1, 1'b1);
    step("r_hs2",  1'b0, 32'h0, 1'b1, 1'b1);
    step("r_dr1",  1'b0, 32'h0, 1'b1, 1'b1);
    step("r_dr2",  1'b0, 32'h0, 1'b1, 1'b1);
    step("r_idle", 1'b0, 32'h0, 1'b1, 1'b1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      logic [31:0] pc;
      bit          en, rdy, rst_n;
      pc = $urandom();
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      en    = ($urandom_range(0, 2) != 0);
      rdy   = ($urandom_range(0, 1) != 0);
      rst_n = ($urandom_range(0, 59) != 0);
      step("rand", en, pc, rdy, rst_n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
